seq_addsub: RTL
===============

SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001: Parameter N, default 8, operand and result width in bits.
REQ-002: Parameter K, default 4, chunk width processed per cycle; N mod K SHALL be 0 and 1 <= K <= N.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: in_valid  input  1  operands and mode presented.
REQ-006: in_ready  output  1  block accepts operands this cycle.
REQ-007: a  input  N  operand A, two's complement or unsigned.
REQ-008: b  input  N  operand B.
REQ-009: sub  input  1  0 = A+B, 1 = A-B.
REQ-010: out_valid  output  1  result and flags valid.
REQ-011: out_ready  input  1  consumer accepts result.
REQ-012: s  output  N  result.
REQ-013: c_out  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned).
REQ-014: ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-015: z  output  1  result equals zero.

Function
REQ-016: The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-017: IDLE: in_ready=1, out_valid=0; on in_valid=1, capture a, b XOR {N{sub}}, carry register = sub, chunk counter = 0, and go to RUN.
REQ-018: RUN: in_ready=0, out_valid=0; each cycle, add chunk [idx*K +: K] of the captured A, the captured B and the carry register, write the K-bit sum into s at the same position, and update the carry register.
REQ-019: Chunk counter SHALL step 0..N/K-1; on the cycle processing chunk N/K-1, record the MSB carry-in for ovf and go to DONE.
REQ-020: Latency: out_valid SHALL rise exactly N/K cycles after the accepting edge (N=8, K=4: 2 cycles; K=N: 1 cycle).
REQ-021: DONE: out_valid=1, in_ready=0; s, c_out, ovf and z SHALL be held stable until out_valid and out_ready are both high, then the FSM returns to IDLE on that edge.
REQ-022: No back-to-back acceptance: the next operand SHALL be accepted no earlier than the cycle after the result handshake.
REQ-023: in_valid, a, b and sub SHALL be ignored in RUN and DONE; operand changes after capture SHALL NOT affect the result.
REQ-024: The result SHALL equal (A + B + 0) mod 2^N for add and (A + ~B + 1) mod 2^N for subtract, bit-exact for every N and K.
REQ-025: c_out, ovf and z SHALL be registered and valid only while out_valid=1; s SHALL hold its last value in IDLE.
REQ-026: out_ready in IDLE or RUN SHALL have no effect.

Reset
REQ-027: While rst=1, asynchronously: FSM=IDLE, counter=0, carry=0, s=0, c_out=0, ovf=0, z=0, out_valid=0, in_ready=1.
REQ-028: Reset asserted in RUN or DONE SHALL abort the operation with no partial result and no out_valid pulse; the first accept SHALL be possible on the first rising edge after rst deasserts.

Verification (N=8, K=4 unless stated)
REQ-029: add a=0x3C, b=0x05 -> s=0x41, c_out=0, ovf=0, z=0; out_valid 2 cycles after accept.
REQ-030: sub a=0x05, b=0x07 -> s=0xFE, c_out=0 (borrow), ovf=0; sub a=0x80, b=0x01 -> s=0x7F, c_out=1, ovf=1.
REQ-031: add a=0xFF, b=0x01 -> s=0x00, c_out=1, ovf=0, z=1; add a=0x7F, b=0x01 -> s=0x80, ovf=1.
REQ-032: Hold out_ready=0 for 5 cycles in DONE while in_valid toggles with new operands -> s/flags stable, in_ready=0, no new capture; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033: Assert rst one cycle into RUN -> all outputs to reset values immediately, no out_valid; a fresh add 0x01+0x01 after release -> s=0x02.
REQ-034: Random regression over K in {1, 2, 4, 8} and N=16, K=4 against a reference model -> bit-exact s/c_out/ovf/z, latency N/K.

Source files
------------

// File: rtl/seq_addsub.sv
// Sequential K-bit-per-cycle adder/subtractor with a valid/ready handshake on
// both sides; an N-bit operation takes N/K cycles and the result is held until consumed.
module seq_addsub #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf,
    output logic         z
);

    localparam int NCH = N / K;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);
    localparam logic [BW-1:0] STEP = BW'(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           carry;
    logic [CW-1:0]  idx;
    // bit offset of the current chunk, kept alongside idx to avoid a multiplier
    logic [BW-1:0]  base;

    logic [K-1:0]   a_chunk;
    logic [K-1:0]   b_chunk;
    logic [K-1:0]   sum_chunk;
    logic           carry_next;
    logic           msb_cin;
    logic [N-1:0]   s_next;

    // One chunk of the ripple: K-bit add, carry into the chunk MSB, merged result
    always_comb begin
        a_chunk = op_a[base +: K];
        b_chunk = op_b[base +: K];
        {carry_next, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry};
        msb_cin = a_chunk[K-1] ^ b_chunk[K-1] ^ sum_chunk[K-1];
        s_next = s;
        s_next[base +: K] = sum_chunk;
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            base      <= '0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            z         <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // subtract is A + ~B + 1: invert B here, the +1 rides in as carry-in
                        op_a     <= a;
                        op_b     <= b ^ {N{sub}};
                        carry    <= sub;
                        idx      <= '0;
                        base     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    s     <= s_next;
                    carry <= carry_next;
                    if (idx == LAST) begin
                        c_out     <= carry_next;
                        ovf       <= msb_cin ^ carry_next;
                        z         <= (s_next == {N{1'b0}});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx  <= idx + CW'(1);
                        base <= base + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
